// File: rtl/miner_slave_regs_pkg.sv
// Shared constants for the miner slave register block: field widths, word
// addresses, status bit positions and the command FSM state type.
package miner_regs_pkg;

    localparam int MSG_W  = 408;
    localparam int TGT_W  = 256;
    localparam int HASH_W = 256;

    localparam logic [4:0] CTRL_A    = 5'd0;
    localparam logic [4:0] CLR_A     = 5'd1;
    localparam logic [4:0] MSG_LO_A  = 5'd3;
    localparam logic [4:0] MSG_HI_A  = 5'd15;
    localparam logic [4:0] TGT_LO_A  = 5'd16;
    localparam logic [4:0] TGT_HI_A  = 5'd23;
    localparam logic [4:0] HASH_LO_A = 5'd24;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_FOUND = 2;
    localparam int ST_ERR   = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TGT_PULSE = 2'd1,
        MSG_PULSE = 2'd2,
        RUN       = 2'd3
    } cmd_state_e;

endpackage

// File: rtl/miner_slave_regs_if.sv
// Avalon-MM slave bus bundle between the host and the miner register block.
interface miner_slave_regs_if;

    logic [4:0]  slaveAddr;
    logic [31:0] slaveWriteData;
    logic        slaveWrite;
    logic        slaveRead;
    logic        slaveChipSelect;
    logic [31:0] slaveReadData;

    modport master (
        output slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
        input  slaveReadData
    );

    modport slave (
        input  slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
        output slaveReadData
    );

endinterface

// File: rtl/miner_slave_regs_cmd_fsm.sv
// Command sequencer: turns an accepted CTRL write into registered
// newTarget/newMsg pulses and tracks the hashing run until coreDone.
//
//   state     | meaning
//   IDLE      | no command in flight, register writes accepted
//   TGT_PULSE | newTarget high for one cycle
//   MSG_PULSE | newMsg high for one cycle, done/found cleared
//   RUN       | core hashing, waiting for coreDone
module miner_cmd_fsm
    import miner_regs_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ctrl_wr_i,
    input  logic [1:0] ctrl_cmd_i,
    input  logic       core_done_i,
    output logic       busy_o,
    output logic       new_target_o,
    output logic       new_msg_o,
    output logic       run_done_o
);

    cmd_state_e state_q, state_d;
    logic       both_q, both_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            both_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            both_q  <= both_d;
        end
    end

    always_comb begin
        state_d = state_q;
        both_d  = both_q;
        case (state_q)
            IDLE: begin
                if (ctrl_wr_i) begin
                    both_d = &ctrl_cmd_i;
                    if (ctrl_cmd_i[0])      state_d = TGT_PULSE;
                    else if (ctrl_cmd_i[1]) state_d = MSG_PULSE;
                end
            end
            TGT_PULSE: state_d = both_q ? MSG_PULSE : IDLE;
            MSG_PULSE: state_d = RUN;
            RUN:       if (core_done_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != IDLE);
        new_target_o = (state_q == TGT_PULSE);
        new_msg_o    = (state_q == MSG_PULSE);
        run_done_o   = (state_q == RUN) && core_done_i;
    end

endmodule

// File: rtl/miner_slave_regs.sv
// Avalon-MM register front end of the miner: message/target shadow registers,
// command pulses to the hashing core, and captured hash/status for readback.
module miner_slave_regs
    import miner_regs_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    miner_slave_regs_if.slave  bus,
    output logic               newTarget,
    output logic               newMsg,
    output logic [TGT_W-1:0]   inputTarget,
    output logic [MSG_W-1:0]   inputMsg,
    input  logic               coreDone,
    input  logic               validBTC,
    input  logic [HASH_W-1:0]  SHAoutput
);

    logic [4:0]        addr;
    logic [31:0]       wd;
    logic              wr, rd, busy, run_done, shadow_wr;
    logic [8:0]        msg_lsb;
    logic [7:0]        word_lsb;
    logic [31:0]       rd_word;

    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [TGT_W-1:0]  tgt_q, tgt_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic              done_q, done_d, found_q, found_d, err_q, err_d;
    logic [31:0]       rdata_q;

    assign addr      = bus.slaveAddr;
    assign wd        = bus.slaveWriteData;
    assign wr        = bus.slaveChipSelect & bus.slaveWrite;
    assign rd        = bus.slaveChipSelect & bus.slaveRead;
    assign shadow_wr = wr && (addr == CTRL_A || (addr >= MSG_LO_A && addr <= TGT_HI_A));

    // Message words sit 24 bits up because addr3 only holds the low 24 bits.
    assign msg_lsb  = {addr[3:0], 5'b0} - 9'd104;
    assign word_lsb = {addr[2:0], 5'b0};

    miner_cmd_fsm u_cmd_fsm (
        .clk          (clk),
        .n_rst        (n_rst),
        .ctrl_wr_i    (wr && addr == CTRL_A),
        .ctrl_cmd_i   (wd[1:0]),
        .core_done_i  (coreDone),
        .busy_o       (busy),
        .new_target_o (newTarget),
        .new_msg_o    (newMsg),
        .run_done_o   (run_done)
    );

    always_comb begin
        msg_d   = msg_q;
        tgt_d   = tgt_q;
        hash_d  = hash_q;
        done_d  = done_q;
        found_d = found_q;
        err_d   = err_q;
        if (shadow_wr && busy) begin
            err_d = 1'b1;
        end else if (wr) begin
            if (addr == MSG_LO_A)
                msg_d[23:0] = wd[31:8];
            else if (addr > MSG_LO_A && addr <= MSG_HI_A)
                msg_d[msg_lsb +: 32] = wd;
            else if (addr >= TGT_LO_A && addr <= TGT_HI_A)
                tgt_d[word_lsb +: 32] = wd;
        end
        if (wr && addr == CLR_A) begin
            if (wd[ST_DONE])  done_d  = 1'b0;
            if (wd[ST_FOUND]) found_d = 1'b0;
            if (wd[ST_ERR])   err_d   = 1'b0;
        end
        if (newMsg) begin
            done_d  = 1'b0;
            found_d = 1'b0;
        end
        // Capture is applied last so it beats a same-cycle CLR write.
        if (run_done) begin
            hash_d  = SHAoutput;
            found_d = validBTC;
            done_d  = 1'b1;
        end
    end

    always_comb begin
        rd_word = '0;
        if (addr == CTRL_A) begin
            rd_word[ST_BUSY]  = busy;
            rd_word[ST_DONE]  = done_q;
            rd_word[ST_FOUND] = found_q;
            rd_word[ST_ERR]   = err_q;
        end else if (addr == MSG_LO_A) begin
            rd_word = {msg_q[23:0], 8'h00};
        end else if (addr > MSG_LO_A && addr <= MSG_HI_A) begin
            rd_word = msg_q[msg_lsb +: 32];
        end else if (addr >= TGT_LO_A && addr <= TGT_HI_A) begin
            rd_word = tgt_q[word_lsb +: 32];
        end else if (addr >= HASH_LO_A) begin
            rd_word = hash_q[word_lsb +: 32];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            msg_q   <= '0;
            tgt_q   <= '0;
            hash_q  <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            msg_q   <= msg_d;
            tgt_q   <= tgt_d;
            hash_q  <= hash_d;
            done_q  <= done_d;
            found_q <= found_d;
            err_q   <= err_d;
            if (rd) rdata_q <= rd_word;
        end
    end

    assign bus.slaveReadData = rdata_q;
    assign inputTarget       = tgt_q;
    assign inputMsg          = msg_q;

endmodule

// File: tb/tb_miner_slave_regs.sv
// Bench for miner_slave_regs: directed scenarios plus random bus/core traffic,
// checked every cycle against a word-array model of the register map.
module tb_miner_slave_regs;
    import miner_regs_pkg::*;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         newTarget, newMsg;
    logic [255:0] inputTarget;
    logic [407:0] inputMsg;
    logic         coreDone = 1'b0;
    logic         validBTC = 1'b0;
    logic [255:0] SHAoutput = '0;

    miner_slave_regs_if bus ();

    miner_slave_regs dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .bus         (bus),
        .newTarget   (newTarget),
        .newMsg      (newMsg),
        .inputTarget (inputTarget),
        .inputMsg    (inputMsg),
        .coreDone    (coreDone),
        .validBTC    (validBTC),
        .SHAoutput   (SHAoutput)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    localparam logic [255:0] SHA_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TGT_VAL = {32'h0FFFFFFF, {7{32'hFFFFFFFF}}};

    // Model: readback words by address, hash words, flags, and a pulse queue
    // (1 = target pulse, 2 = message pulse) that describes the command flow.
    logic [31:0] m_w [32];
    logic [31:0] m_h [8];
    bit          m_done, m_found, m_err, m_run;
    int          m_cur;
    int          m_pend [$];
    logic [31:0] m_rdata;

    function automatic bit m_busy();
        return (m_cur != 0) || m_run;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0)              return {28'd0, m_err, m_found, m_done, m_busy()};
        if (a >= 3 && a <= 23)   return m_w[a];
        if (a >= 24)             return m_h[a-24];
        return 32'd0;
    endfunction

    function automatic logic [407:0] exp_msg();
        logic [407:0] v;
        v = 408'(m_w[3] >> 8);
        for (int k = 4; k <= 15; k++) v = v | (408'(m_w[k]) << (32*(k-3) - 8));
        return v;
    endfunction

    function automatic logic [255:0] exp_tgt();
        logic [255:0] v;
        v = '0;
        for (int k = 16; k <= 23; k++) v = v | (256'(m_w[k]) << (32*(k-16)));
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 32; i++) m_w[i] = '0;
        for (int i = 0; i < 8; i++)  m_h[i] = '0;
        m_done = 0; m_found = 0; m_err = 0; m_run = 0; m_cur = 0;
        m_pend.delete();
        m_rdata = '0;
    endtask

    task automatic model_step();
        bit wr, rd, busy, run_old;
        int a, cur_old;
        logic [31:0] d;
        wr = bus.slaveChipSelect && bus.slaveWrite;
        rd = bus.slaveChipSelect && bus.slaveRead;
        a  = int'(bus.slaveAddr);
        d  = bus.slaveWriteData;
        busy = m_busy();
        run_old = m_run;
        cur_old = m_cur;
        if (rd) m_rdata = m_read(a);
        if (wr) begin
            if (busy && (a == 0 || (a >= 3 && a <= 23))) m_err = 1;
            else if (a == 0) begin
                if (d[0]) m_pend.push_back(1);
                if (d[1]) m_pend.push_back(2);
            end else if (a == 1) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_found = 0;
                if (d[3]) m_err = 0;
            end else if (a == 3) m_w[3] = d & 32'hFFFFFF00;
            else if (a >= 4 && a <= 23) m_w[a] = d;
        end
        if (cur_old == 2) begin
            m_done = 0; m_found = 0; m_run = 1;
        end
        if (run_old && coreDone) begin
            for (int i = 0; i < 8; i++) m_h[i] = 32'(SHAoutput >> (32*i));
            m_found = validBTC;
            m_done = 1;
            m_run = 0;
        end
        m_cur = (m_pend.size() > 0) ? m_pend.pop_front() : 0;
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) reset_model();
            else        model_step();
        end
    end

    task automatic check(input string name, input logic [407:0] act, input logic [407:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("rdata",       408'(bus.slaveReadData), 408'(m_rdata));
            check("newTarget",   408'(newTarget), 408'(m_cur == 1));
            check("newMsg",      408'(newMsg), 408'(m_cur == 2));
            check("inputTarget", 408'(inputTarget), 408'(exp_tgt()));
            check("inputMsg",    inputMsg, exp_msg());
        end
    end

    task automatic bus_write(input int a, input logic [31:0] d);
        bus.slaveAddr = 5'(a); bus.slaveWriteData = d;
        bus.slaveWrite = 1'b1; bus.slaveChipSelect = 1'b1;
        @(negedge clk);
        bus.slaveWrite = 1'b0; bus.slaveChipSelect = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        bus.slaveAddr = 5'(a); bus.slaveRead = 1'b1; bus.slaveChipSelect = 1'b1;
        @(negedge clk);
        bus.slaveRead = 1'b0; bus.slaveChipSelect = 1'b0;
        d = bus.slaveReadData;
    endtask

    task automatic core_done(input logic [255:0] h, input logic v);
        coreDone = 1'b1; SHAoutput = h; validBTC = v;
        @(negedge clk);
        coreDone = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  r;
        logic [255:0] h;
        bus.slaveAddr = '0; bus.slaveWriteData = '0;
        bus.slaveWrite = 1'b0; bus.slaveRead = 1'b0; bus.slaveChipSelect = 1'b0;
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        chk_en = 1'b1;
        check("rst_target", 408'(inputTarget), 408'd0);
        bus_read(0, r);
        check("rst_status", 408'(r), 408'd0);

        // Target load and single newTarget pulse
        bus_write(23, 32'h0FFFFFFF);
        for (int k = 22; k >= 16; k--) bus_write(k, 32'hFFFFFFFF);
        bus_write(0, 32'h1);
        check("tgt_pulse_on", 408'(newTarget), 408'd1);
        @(negedge clk);
        check("tgt_pulse_off", 408'(newTarget), 408'd0);
        check("tgt_value", 408'(inputTarget), 408'(TGT_VAL));
        bus_read(0, r);
        check("status_after_tgt", 408'(r), 408'd0);

        // Message load and start
        bus_write(15, 32'h00000061);
        bus_write(3, 32'hAABBCCDD);
        bus_write(0, 32'h2);
        check("msg_pulse_on", 408'(newMsg), 408'd1);
        check("msg_hi_word", 408'(inputMsg[407:376]), 408'h61);
        check("msg_lo_24", 408'(inputMsg[23:0]), 408'hAABBCC);
        bus_read(0, r);
        check("status_busy", 408'(r), 408'h1);

        // Hash capture and readback
        core_done(SHA_EMPTY, 1'b1);
        bus_read(0, r);
        check("status_found", 408'(r), 408'h6);
        bus_read(31, r);
        check("hash_hi", 408'(r), 408'he3b0c442);
        bus_read(24, r);
        check("hash_lo", 408'(r), 408'h7852b855);
        bus_read(3, r);
        check("msg_addr3_read", 408'(r), 408'hAABBCC00);

        // Writes while busy are dropped and flag err
        bus_write(0, 32'h2);
        bus_write(16, 32'h12345678);
        bus_write(0, 32'h1);
        check("busy_no_pulse", 408'(newTarget), 408'd0);
        check("busy_tgt_kept", 408'(inputTarget), 408'(TGT_VAL));
        bus_read(0, r);
        check("status_err", 408'(r), 408'h9);
        bus_write(1, 32'h8);
        bus_read(0, r);
        check("status_err_clr", 408'(r), 408'h1);
        core_done(256'h1, 1'b0);
        bus_read(0, r);
        check("status_done_only", 408'(r), 408'h2);

        // Combined command; CLR collides with coreDone
        bus_write(0, 32'h3);
        check("both_tgt", 408'({newTarget, newMsg}), 408'b10);
        @(negedge clk);
        check("both_msg", 408'({newTarget, newMsg}), 408'b01);
        @(negedge clk);
        coreDone = 1'b1; SHAoutput = SHA_EMPTY; validBTC = 1'b1;
        bus_write(1, 32'h6);
        coreDone = 1'b0;
        bus_read(0, r);
        check("set_beats_clr", 408'(r), 408'h6);

        // Reset in the middle of a run
        bus_write(0, 32'h2);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("rst_mid_outs", 408'({newTarget, newMsg, bus.slaveReadData}), 408'd0);
        check("rst_mid_msg", inputMsg, 408'd0);
        check("rst_mid_tgt", 408'(inputTarget), 408'd0);
        @(negedge clk);
        n_rst = 1'b1;
        core_done(SHA_EMPTY, 1'b1);
        bus_read(0, r);
        check("late_done_ignored", 408'(r), 408'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            bus.slaveChipSelect = ($urandom % 4) != 0;
            bus.slaveWrite      = ($urandom % 3) == 0;
            bus.slaveRead       = ($urandom % 2) == 1;
            bus.slaveAddr       = (($urandom % 5) == 0) ? 5'd0 : 5'($urandom);
            bus.slaveWriteData  = $urandom;
            coreDone            = ($urandom % 5) == 0;
            validBTC            = ($urandom % 2) == 1;
            for (int j = 0; j < 8; j++) h[32*j +: 32] = $urandom;
            SHAoutput = h;
            @(negedge clk);
        end
        bus.slaveChipSelect = 1'b0; bus.slaveWrite = 1'b0; bus.slaveRead = 1'b0;
        coreDone = 1'b0;
        for (int a = 0; a < 32; a++) bus_read(a, r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/miner_slave_regs.md
Name: miner_slave_regs

Overview:
Avalon-MM slave register front end of the miner. It decodes bus writes into the message and target shadow registers and issues one-cycle command pulses (newTarget/newMsg) to the hashing core. It captures the core's hash result and status flags and returns them on bus reads.

Parameters:
MSG_W, 408, message bits delivered to core
TGT_W, 256, target width
HASH_W, 256, hash result width

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
slaveAddr  in  5  word address
slaveWriteData  in  32  write data
slaveWrite  in  1  write strobe
slaveRead  in  1  read strobe
slaveChipSelect  in  1  slave select; qualifies slaveWrite/slaveRead
slaveReadData  out  32  registered read data
newTarget  out  1  one-cycle pulse: inputTarget valid, core latches it
newMsg  out  1  one-cycle pulse: inputMsg valid, core starts hashing
inputTarget  out  TGT_W  target shadow register
inputMsg  out  MSG_W  message shadow register
coreDone  in  1  one-cycle pulse: hash finished
validBTC  in  1  core hash<=target flag, sampled on coreDone
SHAoutput  in  HASH_W  core hash, sampled on coreDone

Behaviour:
- Clock and reset: single clock clk; reset n_rst is asynchronous, active-low. All registers, outputs and flags reset to 0; FSM resets to IDLE.
- Qualifiers: wr = slaveChipSelect & slaveWrite; rd = slaveChipSelect & slaveRead.
- Address map for writes:
  - 0 CTRL: bit0 load target, bit1 start message.
  - 1 CLR: write-1-to-clear, bit1 done, bit2 found, bit3 err.
  - 2: reserved.
  - 3..15 MSG: addr k (4..15) -> inputMsg[32*(k-3)+23 -: 32]; addr15 -> [407:376], addr4 -> [55:24]; addr3 -> inputMsg[23:0] = wd[31:8], wd[7:0] dropped.
  - 16..23 TGT: addr k -> inputTarget[32*(k-16)+31 -: 32]; addr23 -> [255:224].
  - 24..31: read-only; writes ignored, no error.
- Address map for reads:
  - 0 STATUS = {28'b0, err, found, done, busy}; busy = (state != IDLE).
  - 3..23 return the shadow registers with the same mapping as writes; addr3 returns {msg[23:0], 8'h00}.
  - 24..31 HASH: addr k -> hash[32*(k-24)+31 -: 32].
  - 1, 2 read 0.
- Read latency: exactly 1. slaveReadData is updated on the clock after rd and holds its value otherwise.
- FSM: IDLE, TGT_PULSE, MSG_PULSE, RUN.
  - IDLE, CTRL write: wd[1:0]=01 -> TGT_PULSE; 10 -> MSG_PULSE; 11 -> TGT_PULSE then MSG_PULSE; 00 -> no effect.
  - TGT_PULSE: newTarget=1 for this cycle only; next state MSG_PULSE if the latched command was 11, else IDLE.
  - MSG_PULSE: newMsg=1 for this cycle only; clears done and found; next state RUN.
  - RUN: on coreDone, capture hash<=SHAoutput, found<=validBTC, done<=1; next state IDLE.
- Outputs are registered: the first pulse asserts on the cycle after the accepting CTRL write edge.
- While state != IDLE: any write to CTRL, MSG or TGT is dropped, no register changes, and err<=1 (sticky).
- Stray coreDone outside RUN is ignored.
- Simultaneous coreDone and CLR write in the same cycle: the set wins, so done and found end at their captured values.
- Simultaneous rd and wr to the same address: the read returns the pre-write value.
- Reset mid-RUN: everything clears and the FSM returns to IDLE; a later coreDone is ignored.

Decomposition:
- Package miner_regs_pkg holds:
  - address constants CTRL_A=0, CLR_A=1, MSG_LO_A=3, MSG_HI_A=15, TGT_LO_A=16, TGT_HI_A=23, HASH_LO_A=24;
  - status bit indices;
  - state enum typedef.
- Optional sub-module miner_cmd_fsm holds the FSM and pulse generation; word-register decode stays in the top.

Test Plan:
- Load target 256'h0FFF…FFFF via addr23..16, then CTRL=1 -> one newTarget pulse on the cycle after the CTRL edge, inputTarget equals the value, STATUS reads 0 afterwards.
- Write addr15=0x00000061, addr3=0xAABBCCDD, then CTRL=2 -> inputMsg[407:376]=0x61, inputMsg[23:0]=0xAABBCC, one newMsg pulse, STATUS=0x1.
- In RUN, drive coreDone with SHAoutput=0xe3b0c442…b855, validBTC=1 -> STATUS=0x6; reads of addr31 return 0xe3b0c442 and addr24 return 0x7852b855, each one cycle after the read strobe.
- In RUN, write addr16=0x12345678 and CTRL=1 -> inputTarget unchanged, no pulse, STATUS bit3=1; CLR=0x8 -> bit3=0.
- CTRL=3 -> newTarget pulse then newMsg pulse on consecutive cycles; CLR=0x6 in the same cycle as coreDone -> done=1 retained.
- Assert n_rst low mid-RUN -> all outputs 0; after release, a late coreDone leaves STATUS=0.
